// File: rtl/complex_pkg.sv
// Shared definitions for the complex row-accumulate path: element layout,
// lane slicing, the all-zero element and the row feeder FSM encoding.
`ifndef COMPLEX_PKG_MACROS
`define COMPLEX_PKG_MACROS
// Lane k of a packed row built from w-bit elements, lane 0 in the LSBs.
`define CPX_LANE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package complex_pkg;

    localparam int ELEMENT_WIDTH = 64;
    localparam int NO_OF_UNITS   = 8;
    localparam int LEN_WIDTH     = 16;
    localparam int PART_WIDTH    = ELEMENT_WIDTH / 2;

    // Real part lives in the upper half of an element, imaginary in the lower.
    typedef struct packed {
        logic [PART_WIDTH-1:0] re;
        logic [PART_WIDTH-1:0] im;
    } complex_t;

    localparam complex_t COMPLEX_ZERO = '{re: '0, im: '0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
    } feed_state_t;

endpackage

// File: rtl/complex_row_buffer.sv
// Two-entry row FIFO between the packer and the row organizer. A push into a
// full buffer is taken when a pop happens on the same edge.
module complex_row_buffer
    import complex_pkg::*;
#(
    parameter int W = NO_OF_UNITS * ELEMENT_WIDTH + 2
) (
    input  logic         clk,
    input  logic         main_reset,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge main_reset) begin
        if (!main_reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= !r_wptr;
            end
            if (w_do_pop)
                r_rptr <= !r_rptr;
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/complex_row_feeder.sv
// Packs a serial stream of complex elements into no_of_units-wide rows, zero-pads
// the final partial row and hands rows to the organizer through a 2-entry buffer.
module complex_row_feeder
    import complex_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int len_width     = LEN_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 main_reset,
    input  logic                                 start,
    input  logic [len_width-1:0]                 row_len,
    input  logic [element_width-1:0]             elem_in,
    input  logic                                 elem_valid,
    output logic                                 elem_ready,
    output logic [no_of_units*element_width-1:0] row_out,
    output logic                                 row_valid,
    input  logic                                 row_ready,
    output logic                                 row_first,
    output logic                                 row_last,
    output logic                                 feed_done
);

    localparam int ROW_W  = no_of_units * element_width;
    localparam int BUF_W  = ROW_W + 2;
    localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;

    feed_state_t            r_state;
    logic                   r_start_d;
    logic [len_width-1:0]   r_len;
    logic [len_width-1:0]   r_elem_cnt;
    logic [LANE_W-1:0]      r_lane;
    logic [ROW_W-1:0]       r_row;
    logic                   r_first_pend;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_accept;
    logic                   w_lane_wrap;
    logic                   w_is_last;
    logic [len_width-1:0]   w_cnt_nxt;
    logic [ROW_W-1:0]       w_fill_row;
    logic [ROW_W-1:0]       w_pad_row;
    logic                   w_push;
    logic [ROW_W-1:0]       w_push_row;
    logic                   w_push_last;
    logic [BUF_W-1:0]       w_buf_out;

    assign w_pop       = !w_empty && row_ready;
    assign w_push_ok   = !w_full || w_pop;
    assign elem_ready  = (r_state == ST_FILL) && w_push_ok;
    assign w_accept    = elem_valid && elem_ready;
    assign w_lane_wrap = (r_lane == LANE_W'(no_of_units - 1));
    assign w_cnt_nxt   = r_elem_cnt + len_width'(1);
    assign w_is_last   = (w_cnt_nxt == r_len);

    // Row as it looks once the incoming element lands, so a full row can be
    // pushed on the same edge its last lane is written.
    always_comb begin
        w_fill_row = r_row;
        `CPX_LANE(w_fill_row, r_lane, element_width) = elem_in;
    end

    always_comb begin
        w_pad_row = r_row;
        for (int k = 0; k < no_of_units; k++)
            if (k >= int'(r_lane))
                `CPX_LANE(w_pad_row, k, element_width) = element_width'(COMPLEX_ZERO);
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_row  = w_fill_row;
        w_push_last = w_is_last;
        if (start) begin
            case (r_state)
                ST_FILL: w_push = w_accept && w_lane_wrap;
                ST_PAD: begin
                    w_push      = w_push_ok;
                    w_push_row  = w_pad_row;
                    w_push_last = 1'b1;
                end
                default: w_push = 1'b0;
            endcase
        end
    end

    complex_row_buffer #(.W(BUF_W)) u_buf (
        .clk       (clk),
        .main_reset(main_reset),
        .i_clear   (!start),
        .i_push    (w_push),
        .i_data    ({r_first_pend, w_push_last, w_push_row}),
        .i_pop     (w_pop),
        .o_data    (w_buf_out),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign row_valid = !w_empty;
    assign row_out   = w_empty ? '0 : w_buf_out[ROW_W-1:0];
    assign row_last  = !w_empty && w_buf_out[ROW_W];
    assign row_first = !w_empty && w_buf_out[ROW_W+1];
    // DRAIN with nothing left buffered means the last row has gone.
    assign feed_done = start && (r_state == ST_DRAIN) && w_empty;

    always_ff @(posedge clk or negedge main_reset) begin
        if (!main_reset) begin
            r_state      <= ST_IDLE;
            r_start_d    <= 1'b0;
            r_len        <= '0;
            r_elem_cnt   <= '0;
            r_lane       <= '0;
            r_row        <= '0;
            r_first_pend <= 1'b0;
        end else begin
            r_start_d <= start;
            if (!start) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (!r_start_d) begin
                        r_len        <= row_len;
                        r_elem_cnt   <= '0;
                        r_lane       <= '0;
                        r_first_pend <= 1'b1;
                        r_state      <= (row_len == '0) ? ST_DRAIN : ST_FILL;
                    end
                    ST_FILL: if (w_accept) begin
                        r_row      <= w_fill_row;
                        r_elem_cnt <= w_cnt_nxt;
                        r_lane     <= w_lane_wrap ? '0 : r_lane + LANE_W'(1);
                        if (w_lane_wrap)
                            r_first_pend <= 1'b0;
                        if (w_is_last)
                            r_state <= w_lane_wrap ? ST_DRAIN : ST_PAD;
                    end
                    ST_PAD: if (w_push_ok) begin
                        r_first_pend <= 1'b0;
                        r_state      <= ST_DRAIN;
                    end
                    ST_DRAIN: if (w_empty)
                        r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_complex_row_feeder.sv
// Directed-plus-random bench for complex_row_feeder; rows are checked against
// a list-of-elements model of how a vector splits into zero-padded rows.
module tb_complex_row_feeder;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int LW = 16;
    localparam int RW = EW * NU;

    logic          clk = 1'b0;
    logic          main_reset;
    logic          start;
    logic [LW-1:0] row_len;
    logic [EW-1:0] elem_in;
    logic          elem_valid;
    logic          elem_ready;
    logic [RW-1:0] row_out;
    logic          row_valid;
    logic          row_ready;
    logic          row_first;
    logic          row_last;
    logic          feed_done;

    complex_row_feeder #(.element_width(EW), .no_of_units(NU), .len_width(LW)) dut (
        .clk       (clk),
        .main_reset(main_reset),
        .start     (start),
        .row_len   (row_len),
        .elem_in   (elem_in),
        .elem_valid(elem_valid),
        .elem_ready(elem_ready),
        .row_out   (row_out),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_first (row_first),
        .row_last  (row_last),
        .feed_done (feed_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [EW-1:0] elems[$];
    logic [RW-1:0] got_rows[$];
    bit            got_first[$];
    bit            got_last[$];
    int fd_cnt, fd_cyc, last_xfer, stall_viol, rdy_low, idx_at20, valid_seen, last_idx;
    bit rdy_at20;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [RW-1:0] exp_row(input int r, input int n);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < NU; k++)
            if (NU * r + k < n) v[k*EW +: EW] = elems[NU*r+k];
        return v;
    endfunction

    // rmode: 0 ready always, 1 ready low for 20 cycles, 2 ready toggling.
    task automatic run_vec(input int n, input int rmode, input int vmode, input int pat,
                           input int abort_at);
        int cyc, idx, post;
        bit prev_stall, pf, pl;
        logic [RW-1:0] prow;
        elems.delete(); got_rows.delete(); got_first.delete(); got_last.delete();
        for (int k = 0; k < n; k++)
            elems.push_back(pat == 0 ? {32'(k), 32'(100 + k)} : {$urandom, $urandom});
        fd_cnt = 0; fd_cyc = -1; last_xfer = -100; stall_viol = 0; rdy_low = 0;
        idx_at20 = -1; rdy_at20 = 1'b1; valid_seen = 0;
        cyc = 0; idx = 0; post = 0; prev_stall = 0; pf = 0; pl = 0; prow = '0;
        @(posedge clk); #1;
        start = 1'b0; elem_valid = 1'b0; row_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; row_len = LW'(n);
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            row_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc > 20) : ((cyc % 2) == 1);
            elem_valid = (idx < n) && (vmode == 0 || $urandom_range(0, 1) == 1);
            elem_in    = '0;
            if (idx < n) elem_in = elems[idx];
            @(negedge clk);
            if (prev_stall && (!row_valid || row_out !== prow || row_first !== pf || row_last !== pl))
                stall_viol++;
            prev_stall = row_valid && !row_ready;
            prow = row_out; pf = row_first; pl = row_last;
            if (row_valid) valid_seen++;
            if (row_valid && row_ready) begin
                got_rows.push_back(row_out); got_first.push_back(row_first);
                got_last.push_back(row_last); last_xfer = cyc;
            end
            if (feed_done) begin fd_cnt++; fd_cyc = cyc; end
            if (idx < n && !elem_ready) rdy_low++;
            if (elem_valid && elem_ready) idx++;
            if (cyc == 20) begin idx_at20 = idx; rdy_at20 = elem_ready; end
            last_idx = idx;
            if (abort_at > 0 && idx == abort_at) break;
            if (fd_cnt > 0) post++;
            if (post > 3 || cyc >= 400) break;
        end
        elem_valid = 1'b0;
    endtask

    task automatic verify(input string tag, input int n);
        int nr;
        nr = (n + NU - 1) / NU;
        chk({tag, "_rows"}, got_rows.size(), nr);
        for (int r = 0; r < nr && r < got_rows.size(); r++) begin
            chk($sformatf("%s_row%0d_data", tag, r), got_rows[r], exp_row(r, n));
            chk($sformatf("%s_row%0d_first", tag, r), got_first[r], r == 0);
            chk($sformatf("%s_row%0d_last", tag, r), got_last[r], r == nr - 1);
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_fd_cnt"}, fd_cnt, 1);
        chk({tag, "_fd_cyc"}, fd_cyc, last_xfer + 1);
        chk({tag, "_stall"}, stall_viol, 0);
    endtask

    initial begin
        main_reset = 1'b0; start = 1'b0; row_len = '0; elem_in = '0;
        elem_valid = 1'b0; row_ready = 1'b0;
        #12;
        chk("reset_ctl", {elem_ready, row_valid, row_first, row_last, feed_done}, 5'b0);
        chk("reset_row", row_out, '0);
        @(negedge clk); main_reset = 1'b1;

        run_vec(16, 0, 0, 0, 0);
        verify("t1", 16); check_done("t1");
        chk("t1_rdy_low", rdy_low, 0);

        run_vec(11, 0, 0, 0, 0);
        verify("t2a", 11); check_done("t2a");
        run_vec(3, 0, 0, 1, 0);
        verify("t2b", 3); check_done("t2b");

        run_vec(32, 1, 0, 1, 0);
        chk("t3_idx20", idx_at20, 16);
        chk("t3_rdy20", rdy_at20, 1'b0);
        verify("t3", 32); check_done("t3");

        run_vec(24, 2, 1, 1, 0);
        verify("t4", 24); check_done("t4");

        run_vec(0, 0, 0, 1, 0);
        verify("t5", 0);
        chk("t5_valid", valid_seen, 0);
        chk("t5_fd_cnt", fd_cnt, 1);
        chk("t5_fd_cyc", fd_cyc, 1);

        // Abort with row 0 held in the buffer by a stalled organizer.
        run_vec(16, 1, 0, 1, 10);
        chk("t6_abort_idx", last_idx, 10);
        @(posedge clk); #1;
        start = 1'b0; elem_valid = 1'b0; row_ready = 1'b0;
        @(negedge clk);
        chk("t6_pre_valid", row_valid, 1'b1);
        chk("t6_pre_fd", feed_done, 1'b0);
        @(negedge clk);
        chk("t6_post_ctl", {row_valid, elem_ready, feed_done}, 3'b0);
        chk("t6_rows", got_rows.size(), 0);

        run_vec(8, 0, 0, 1, 0);
        verify("t6r", 8); check_done("t6r");

        run_vec(16, 1, 0, 1, 10);
        chk("t7_pre_valid", row_valid, 1'b1);
        #2;
        main_reset = 1'b0; start = 1'b0;
        #1;
        chk("t7_rst_ctl", {elem_ready, row_valid, row_first, row_last, feed_done}, 5'b0);
        chk("t7_rst_row", row_out, '0);
        @(posedge clk); #1;
        main_reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
